// File: rtl/cacheline_adaptor.sv
// Cache-line <-> memory-burst adaptor: splits line writes into beats and gathers read beats into a line.
// Optional performance counters are enabled by defining CACHELINE_ADAPTOR_PERF_EN.
module cacheline_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  output logic               resp_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  output logic [BURST_W-1:0] burst_o,
  input  logic [BURST_W-1:0] burst_i,
  input  logic               resp_i
`ifdef CACHELINE_ADAPTOR_PERF_EN
  ,
  output logic [31:0]        perf_rd_o,
  output logic [31:0]        perf_wr_o,
  output logic [31:0]        perf_stall_o
`endif
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                          state, state_n;
  logic [CNT_W-1:0]                cnt;
  logic [BEATS-1:0][BURST_W-1:0]   line_q;
  logic [BEATS-1:0][BURST_W-1:0]   wbuf;
  logic                            beat_last;

  // Byte-offset bits are dropped on purpose: memory always sees line-aligned addresses.
  logic unused_offset;
  assign unused_offset = ^address_i[OFF_W-1:0];

  assign beat_last = resp_i && (cnt == LAST_BEAT);
  assign line_o    = line_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // NOTE: every output gets a default first so no path leaves a value unassigned (no latches).
  always_comb begin
    state_n = state;
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;
    burst_o = '0;
    unique case (state)
      IDLE: begin
        if (write_i)     state_n = WRITE;
        else if (read_i) state_n = READ;
      end
      READ: begin
        read_o = 1'b1;
        if (beat_last) state_n = DONE;
      end
      WRITE: begin
        write_o = 1'b1;
        burst_o = wbuf[cnt];
        if (beat_last) state_n = DONE;
      end
      DONE: begin
        resp_o  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: line_q and address_o are reset because they are visible outputs; the write buffer is not,
  // since burst_o is gated to zero outside WRITE and the buffer is always reloaded before use.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      address_o <= '0;
      line_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (write_i || read_i) address_o <= {address_i[ADDR_W-1:OFF_W], OFF_W'(0)};
        end
        READ: begin
          if (resp_i) begin
            line_q[cnt] <= burst_i;
            cnt         <= cnt + CNT_W'(1);
          end
        end
        WRITE: begin
          if (resp_i) cnt <= cnt + CNT_W'(1);
        end
        DONE:    cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && write_i) wbuf <= line_i;
  end

`ifdef CACHELINE_ADAPTOR_PERF_EN
  logic done_rd, done_wr, stall;
  logic rd_was;

  // Remembers which kind of burst led into DONE so the completion is attributed correctly.
  always_ff @(posedge clk) begin
    if (rst)                  rd_was <= 1'b0;
    else if (state == READ)   rd_was <= 1'b1;
    else if (state == WRITE)  rd_was <= 1'b0;
  end

  assign done_rd = (state == DONE) &&  rd_was;
  assign done_wr = (state == DONE) && !rd_was;
  assign stall   = (state == READ || state == WRITE) && !resp_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_rd_o    <= '0;
      perf_wr_o    <= '0;
      perf_stall_o <= '0;
    end else begin
      if (done_rd && perf_rd_o    != '1) perf_rd_o    <= perf_rd_o + 32'd1;
      if (done_wr && perf_wr_o    != '1) perf_wr_o    <= perf_wr_o + 32'd1;
      if (stall   && perf_stall_o != '1) perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule
